data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Responder end of the CPU data-memory interface. The core issues read/write requests on mem_ren/mem_wen/mem_addr/mem_wdata. This block services each request after a programmable number of wait states, holds the core with mem_stall, and signals completion with a one-cycle mem_ack. It replaces the zero-latency data RAM in the CPU wrapper so the pipeline's stall path is exercised against realistic memory timing.

## Interface
- ADDR_WIDTH, 10: word-index width; storage depth is 2**ADDR_WIDTH words, indexed by mem_addr[ADDR_WIDTH+1:2].
- LATENCY, 2: wait-state cycles inserted before the response, legal range 0..15.
- clk  input  1  main clock, all state on rising edge.
- rst  input  1  reset, asynchronous assert, active-low (0 = reset).
- mem_ren  input  1  read request, held by the core until mem_ack.
- mem_wen  input  1  write request, held by the core until mem_ack.
- mem_addr  input  32  byte address; bits above ADDR_WIDTH+1 ignored (wrap-around).
- mem_wdata  input  32  write data; the core's mem_dout.
- mem_rdata  output  32  read data; the core's mem_din.
- mem_stall  output  1  hold the pipeline.
- mem_ack  output  1  request complete, one-cycle pulse.
- mem_err  output  1  misaligned access flag, valid with mem_ack.

## Operation
- FSM states: IDLE, WAIT, RESP.
  - IDLE: a request is seen when mem_ren | mem_wen.
    - Latch the op, address and write data.
    - Load the counter with LATENCY.
    - Go to WAIT if LATENCY > 0, else RESP.
  - WAIT: decrement the counter each cycle. When the counter is 1, the next state is RESP.
  - RESP: mem_ack = 1 for exactly one cycle, then IDLE unconditionally.
- Both mem_ren and mem_wen asserted: treated as a write; mem_rdata unchanged.
- Array access happens on the edge entering RESP, using latched values only. Changes on the inputs after acceptance are ignored.
  - Write: store the latched data.
  - Read: register the array word into mem_rdata.
- mem_rdata holds its value until the next completed read.
- mem_stall = (mem_ren | mem_wen) & ~mem_ack. It is combinational, so it rises in the same cycle the request appears.
- A request still asserted in the cycle after the ack is a new request. It is accepted from IDLE normally.
- The storage array has no reset; its contents are undefined until written.
- Reset (rst = 0) at any time:
  - State goes to IDLE and the counter to 0.
  - mem_ack = 0, mem_rdata = 0, mem_err = 0.
  - A pending write is dropped and the array is untouched.
  - mem_stall still follows its combinational equation.

## Timing
- Request first seen in cycle N (IDLE): mem_ack is high in cycle N+LATENCY+1.
  - LATENCY=0: 1-cycle turnaround.
  - LATENCY=2: ack in N+3.
- mem_rdata is valid in the ack cycle and after it.
- Back-to-back requests: minimum LATENCY+2 cycles per access. There is no pipelining; one outstanding request at a time.
- mem_stall falls in the ack cycle, so the core advances on that edge.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - A latched address with addr[1:0] != 0 completes with normal timing.
  - The write is suppressed and mem_rdata loads 0.
  - mem_err = 1 in the ack cycle only.
- MEM_ALIGN_CHECK_EN undefined:
  - addr[1:0] is ignored and the access goes to the word.
  - mem_err is tied to 0.

## Test plan
- LATENCY=2: write 0xDEADBEEF to 0x10, then read 0x10.
  - Each ack arrives 3 cycles after request.
  - mem_stall is high for 3 cycles per access.
  - mem_rdata = 0xDEADBEEF in the read ack cycle.
- LATENCY=0: back-to-back reads of 0x0 and 0x4 after writing 0x11111111 / 0x22222222.
  - Acks are 2 cycles apart.
  - Data matches each address.
- Wrap-around, ADDR_WIDTH=10: write 0xA5A5A5A5 to 0x1000, read 0x0 → 0xA5A5A5A5.
- Both ren and wen with wdata 0x12345678 at 0x8 → treated as a write. A subsequent read of 0x8 returns 0x12345678, and the preceding mem_rdata is unchanged during the combined request.
- Reset asserted during WAIT of a write of 0xFFFFFFFF to 0x20 (0x20 previously holding 0x0):
  - Outputs are 0 immediately.
  - After release, a read of 0x20 returns 0x0.
- With MEM_ALIGN_CHECK_EN: write 0x55 to 0x22.
  - Ack arrives with mem_err = 1.
  - A read of 0x20 returns the old value.
  - Without the macro, the same write lands at word 0x20 and mem_err stays 0.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder: services one CPU load/store at a time after LATENCY wait states.
// Optional MEM_ALIGN_CHECK_EN flags misaligned accesses with mem_err and suppresses them.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        mem_ack,
  output logic        mem_err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state_q;
  logic [3:0]              cnt_q;
  logic                    wr_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [31:0]             wdata_q;
  logic [31:0]             rdata_q;
  logic                    ack_q;

  logic [31:0]             mem_array [2**ADDR_WIDTH];

  logic                    req;
  logic                    go_resp;
  logic                    acc_wr;
  logic [ADDR_WIDTH-1:0]   acc_idx;
  logic [31:0]             acc_wdata;
  logic                    misaligned;
  logic                    unused_addr;

  assign req         = mem_ren | mem_wen;
  assign unused_addr = ^{mem_addr[31:ADDR_WIDTH+2], mem_addr[1:0]};

  // With zero latency the access happens on the accepting edge, so the
  // not-yet-latched inputs stand in for the latched request.
  assign go_resp   = ((state_q == IDLE) && req && (LATENCY == 0)) ||
                     ((state_q == WAIT) && (cnt_q == 4'd1));
  assign acc_wr    = (state_q == IDLE) ? mem_wen : wr_q;
  assign acc_idx   = (state_q == IDLE) ? mem_addr[ADDR_WIDTH+1:2] : idx_q;
  assign acc_wdata = (state_q == IDLE) ? mem_wdata : wdata_q;

`ifdef MEM_ALIGN_CHECK_EN
  logic [1:0] lsb_q;
  logic       err_q;
  logic [1:0] acc_lsb;

  assign acc_lsb    = (state_q == IDLE) ? mem_addr[1:0] : lsb_q;
  assign misaligned = (acc_lsb != 2'b00);
  assign mem_err    = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lsb_q <= 2'b00;
      err_q <= 1'b0;
    end else begin
      err_q <= go_resp & misaligned;
      if ((state_q == IDLE) && req) begin
        lsb_q <= mem_addr[1:0];
      end
    end
  end
`else
  assign misaligned = 1'b0;
  assign mem_err    = 1'b0;
`endif

  // Storage has no reset; writes are gated by rst so a write cannot land while held in reset.
  always_ff @(posedge clk) begin
    if (rst && go_resp && acc_wr && !misaligned) begin
      mem_array[acc_idx] <= acc_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            wr_q    <= mem_wen;
            idx_q   <= mem_addr[ADDR_WIDTH+1:2];
            wdata_q <= mem_wdata;
            cnt_q   <= 4'(LATENCY);
            state_q <= (LATENCY > 0) ? WAIT : RESP;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase

      if (go_resp) begin
        ack_q <= 1'b1;
        if (!acc_wr) begin
          rdata_q <= misaligned ? 32'h0 : mem_array[acc_idx];
        end
      end
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_ack   = ack_q;
  assign mem_stall = req & ~ack_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance at LATENCY=2, one at LATENCY=0.
// Expectations follow MEM_ALIGN_CHECK_EN when the bench is built with it defined.
module tb_data_mem_responder;

  logic        clk;
  logic        rst;

  logic        renA, wenA, stallA, ackA, errA;
  logic [31:0] addrA, wdataA, rdataA;
  logic        renB, wenB, stallB, ackB, errB;
  logic [31:0] addrB, wdataB, rdataB;

  int checkCount;
  int passCount;
  int cycleNo;

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dutA (
    .clk(clk), .rst(rst),
    .mem_ren(renA), .mem_wen(wenA), .mem_addr(addrA), .mem_wdata(wdataA),
    .mem_rdata(rdataA), .mem_stall(stallA), .mem_ack(ackA), .mem_err(errA)
  );

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(0)) dutB (
    .clk(clk), .rst(rst),
    .mem_ren(renB), .mem_wen(wenB), .mem_addr(addrB), .mem_wdata(wdataB),
    .mem_rdata(rdataB), .mem_stall(stallB), .mem_ack(ackB), .mem_err(errB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleNo <= cycleNo + 1;

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: simulation exceeded its time limit");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    else
      passCount++;
  endtask

  // Drives a request one time step after the next rising edge.
  task automatic applyStimulus(input bit sel, input logic ren, input logic wen,
                               input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge clk);
    #1;
    if (!sel) begin
      renA = ren; wenA = wen; addrA = addr; wdataA = wdata;
    end else begin
      renB = ren; wenB = wen; addrB = addr; wdataB = wdata;
    end
  endtask

  // Offset 0 is the cycle the request was first driven.
  task automatic waitAck(input bit sel, output int ackOff, output int stallCnt, output int ackCycle,
                         output logic [31:0] rdata, output logic err);
    ackOff   = -1;
    stallCnt = 0;
    ackCycle = 0;
    rdata    = 32'h0;
    err      = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (sel ? stallB : stallA) stallCnt++;
      if (sel ? ackB : ackA) begin
        ackOff   = k;
        ackCycle = cycleNo;
        rdata    = sel ? rdataB : rdataA;
        err      = sel ? errB : errA;
        break;
      end
    end
    if (ackOff < 0) checkOutput("ackTimeout", 32'd0, 32'd1);
  endtask

  int          off, stalls, cyc1, cyc2;
  logic [31:0] rd;
  logic        er;
  logic        alignOn;

  initial begin
    checkCount = 0;
    passCount  = 0;
    cycleNo    = 0;
`ifdef MEM_ALIGN_CHECK_EN
    alignOn = 1'b1;
`else
    alignOn = 1'b0;
`endif
    rst = 1'b0;
    renA = 0; wenA = 0; addrA = 0; wdataA = 0;
    renB = 0; wenB = 0; addrB = 0; wdataB = 0;
    repeat (2) @(negedge clk);
    checkOutput("rstAckA",   {31'd0, ackA},   32'd0);
    checkOutput("rstRdataA", rdataA,          32'd0);
    checkOutput("rstErrA",   {31'd0, errA},   32'd0);
    checkOutput("rstStallA", {31'd0, stallA}, 32'd0);
    checkOutput("rstAckB",   {31'd0, ackB},   32'd0);
    checkOutput("rstRdataB", rdataB,          32'd0);
    rst = 1'b1;

    // LATENCY=2 write then read
    applyStimulus(0, 0, 1, 32'h10, 32'hDEADBEEF);
    waitAck(0, off, stalls, cyc1, rd, er);
    checkOutput("wrAckOff",   off,    3);
    checkOutput("wrStallCnt", stalls, 3);
    checkOutput("wrErr",      {31'd0, er}, 32'd0);
    applyStimulus(0, 0, 0, 32'h0, 32'h0);
    applyStimulus(0, 1, 0, 32'h10, 32'h0);
    waitAck(0, off, stalls, cyc1, rd, er);
    checkOutput("rdAckOff",   off,    3);
    checkOutput("rdStallCnt", stalls, 3);
    checkOutput("rdData",     rd,     32'hDEADBEEF);
    applyStimulus(0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("rdDataHold", rdataA, 32'hDEADBEEF);
    checkOutput("ackOnePulse", {31'd0, ackA}, 32'd0);

    // LATENCY=0 writes, then back-to-back reads with ren held
    applyStimulus(1, 0, 1, 32'h0, 32'h11111111);
    waitAck(1, off, stalls, cyc1, rd, er);
    checkOutput("l0WrAckOff", off,    1);
    checkOutput("l0WrStall",  stalls, 1);
    applyStimulus(1, 0, 1, 32'h4, 32'h22222222);
    waitAck(1, off, stalls, cyc1, rd, er);
    applyStimulus(1, 0, 0, 32'h0, 32'h0);
    applyStimulus(1, 1, 0, 32'h0, 32'h0);
    waitAck(1, off, stalls, cyc1, rd, er);
    checkOutput("l0Rd0", rd, 32'h11111111);
    applyStimulus(1, 1, 0, 32'h4, 32'h0);
    waitAck(1, off, stalls, cyc2, rd, er);
    checkOutput("l0Rd4", rd, 32'h22222222);
    checkOutput("l0AckGap", cyc2 - cyc1, 2);
    applyStimulus(1, 0, 0, 32'h0, 32'h0);

    // Address wrap-around
    applyStimulus(0, 0, 1, 32'h1000, 32'hA5A5A5A5);
    waitAck(0, off, stalls, cyc1, rd, er);
    applyStimulus(0, 0, 0, 32'h0, 32'h0);
    applyStimulus(0, 1, 0, 32'h0, 32'h0);
    waitAck(0, off, stalls, cyc1, rd, er);
    checkOutput("wrapRd", rd, 32'hA5A5A5A5);
    applyStimulus(0, 0, 0, 32'h0, 32'h0);

    // ren and wen together behave as a write
    applyStimulus(0, 1, 0, 32'h10, 32'h0);
    waitAck(0, off, stalls, cyc1, rd, er);
    applyStimulus(0, 1, 1, 32'h8, 32'h12345678);
    waitAck(0, off, stalls, cyc1, rd, er);
    checkOutput("bothRdataKept", rd, 32'hDEADBEEF);
    checkOutput("bothAckOff", off, 3);
    applyStimulus(0, 0, 0, 32'h0, 32'h0);
    applyStimulus(0, 1, 0, 32'h8, 32'h0);
    waitAck(0, off, stalls, cyc1, rd, er);
    checkOutput("bothRdBack", rd, 32'h12345678);
    applyStimulus(0, 0, 0, 32'h0, 32'h0);

    // Reset during WAIT of a write drops it
    applyStimulus(0, 0, 1, 32'h20, 32'h0);
    waitAck(0, off, stalls, cyc1, rd, er);
    applyStimulus(0, 0, 0, 32'h0, 32'h0);
    applyStimulus(0, 0, 1, 32'h20, 32'hFFFFFFFF);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("midRstAck",   {31'd0, ackA},   32'd0);
    checkOutput("midRstRdata", rdataA,          32'd0);
    checkOutput("midRstErr",   {31'd0, errA},   32'd0);
    checkOutput("midRstStall", {31'd0, stallA}, 32'd1);
    @(posedge clk);
    #1 wenA = 1'b0;
    #1 checkOutput("midRstStallLow", {31'd0, stallA}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(0, 1, 0, 32'h20, 32'h0);
    waitAck(0, off, stalls, cyc1, rd, er);
    checkOutput("droppedWrite", rd, 32'h0);
    applyStimulus(0, 0, 0, 32'h0, 32'h0);

    // Misaligned write
    applyStimulus(0, 0, 1, 32'h22, 32'h55);
    waitAck(0, off, stalls, cyc1, rd, er);
    checkOutput("misAckOff", off, 3);
    checkOutput("misErr", {31'd0, er}, {31'd0, alignOn});
    applyStimulus(0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("misErrCleared", {31'd0, errA}, 32'd0);
    applyStimulus(0, 1, 0, 32'h20, 32'h0);
    waitAck(0, off, stalls, cyc1, rd, er);
    checkOutput("misRdBack", rd, alignOn ? 32'h0 : 32'h55);
    checkOutput("alignedErr", {31'd0, er}, 32'd0);
    applyStimulus(0, 0, 0, 32'h0, 32'h0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
